// File: rtl/button_pkg.sv
// Shared state encoding and timing defaults for the button press classifier.
// Default cycle counts assume a 27 MHz clock: 1 s long-press hold, 300 ms double-press gap.
package button_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_LONG_HELD = 3'd2,
    ST_GAP       = 3'd3,
    ST_PRESS2    = 3'd4
  } state_t;

  localparam int unsigned DEFAULT_LONG_CYCLES = 27000000;
  localparam int unsigned DEFAULT_GAP_CYCLES  = 8100000;

  // Counter only has to reach max(long, gap) - 1, so clog2 of the larger bound suffices.
  function automatic int cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/button_press_classifier.sv
// Classifies a debounced button into short / long / double press pulses.
// Latency: every output registered, pulses appear the cycle after the deciding edge; no backpressure (fire-and-forget pulses).
module button_press_classifier
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = DEFAULT_LONG_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  localparam int CNT_W = cnt_width(LONG_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             short_d;
  logic             long_d;
  logic             double_d;
  logic             busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (btn_level) begin
          state_d = ST_PRESS1;
          cnt_d   = '0;
        end
      end

      // Release wins over the terminal count, so a hold of exactly LONG_CYCLES is still short.
      ST_PRESS1: begin
        if (!btn_level) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_LONG_HELD: begin
        if (!btn_level) begin
          state_d = ST_IDLE;
        end
      end

      // A press on the terminal gap cycle still counts as the second press.
      ST_GAP: begin
        if (btn_level) begin
          state_d = ST_PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_PRESS2: begin
        if (!btn_level) begin
          state_d  = ST_IDLE;
          double_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      short_press  <= short_d;
      long_press   <= long_d;
      double_press <= double_d;
      busy         <= busy_d;
    end
  end

endmodule
